// File: rtl/bullet_hit_judge_if.sv
// Hit-mask report channel from the bullet hit judge to the enemy controller.
`ifndef GAME_STATUS_BIT_LEN
`define GAME_STATUS_BIT_LEN 2
`endif
`ifndef GAME_STATUS_RUN
`define GAME_STATUS_RUN 2'd1
`endif

interface bullet_hit_judge_if #(
    parameter int ENEMY_NUM = 4
);
    logic [ENEMY_NUM-1:0] hit_mask;
    logic                 hit_valid;
    logic                 hit_ready;

    modport master (
        output hit_mask,
        output hit_valid,
        input  hit_ready
    );

    modport slave (
        input  hit_mask,
        input  hit_valid,
        output hit_ready
    );
endinterface

// File: rtl/bullet_hit_judge.sv
// Per-pixel bullet/enemy collision, per-frame hit-mask reporting and
// saturating score keeping for the player bullet layer.
`ifndef GAME_STATUS_BIT_LEN
`define GAME_STATUS_BIT_LEN 2
`endif
`ifndef GAME_STATUS_RUN
`define GAME_STATUS_RUN 2'd1
`endif

module bullet_hit_judge #(
    parameter int ENEMY_NUM     = 4,
    parameter int SCORE_WIDTH   = 14,
    parameter int SCORE_PER_HIT = 1,
    parameter int SCORE_MAX     = 9999
) (
    input  logic                            clk_vga,
    input  logic                            rst,
    input  logic [`GAME_STATUS_BIT_LEN-1:0] game_status_i,
    input  logic                            frame_start_i,
    input  logic                            frame_end_i,
    input  logic                            bullet_alpha_i,
    input  logic [ENEMY_NUM-1:0]            enemy_alpha_i,
    input  logic                            score_clr_i,
    output logic                            crash_enemy_bullet_o,
    bullet_hit_judge_if.master              hit_if,
    output logic [SCORE_WIDTH-1:0]          score_o,
    output logic                            report_drop_o
);

    localparam int SUM_W = SCORE_WIDTH + 4;
    localparam logic [SUM_W-1:0] PER_HIT_W = SUM_W'(SCORE_PER_HIT);
    localparam logic [SUM_W-1:0] MAX_W     = SUM_W'(SCORE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } state_e;

    state_e               state_q, state_d;
    logic [ENEMY_NUM-1:0] acc_q, acc_d;
    logic [ENEMY_NUM-1:0] mask_q, mask_d;
    logic                 valid_q, valid_d;
    logic                 drop_q, drop_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;

    logic                 run;
    logic                 handshake;
    logic [ENEMY_NUM-1:0] hit_vec;
    logic [ENEMY_NUM-1:0] acc_final;
    logic [SUM_W-1:0]     pop;
    logic [SUM_W-1:0]     sum;

    assign run       = (game_status_i == `GAME_STATUS_RUN);
    assign handshake = valid_q & hit_if.hit_ready;
    assign hit_vec   = {ENEMY_NUM{bullet_alpha_i}} & enemy_alpha_i;
    // A frame_start pixel clears first, so its own hits land in the fresh frame.
    assign acc_final = (frame_start_i ? '0 : acc_q) | hit_vec;

    // Zero-latency collision flag, aligned with the bullet block's pixel.
    assign crash_enemy_bullet_o = run & bullet_alpha_i & (|enemy_alpha_i);

    assign hit_if.hit_mask  = mask_q;
    assign hit_if.hit_valid = valid_q;
    assign score_o          = score_q;
    assign report_drop_o    = drop_q;

    // Score increment: popcount of the reported mask, widened so it never wraps.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < ENEMY_NUM; i++) begin
            pop = pop + SUM_W'(mask_q[i]);
        end
        sum = SUM_W'(score_q) + pop * PER_HIT_W;
    end

    // Next-state logic for the frame accumulator, report FSM and score.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        score_d = score_q;

        if (!run) begin
            // Leaving RUN abandons any pending report without flagging a drop.
            acc_d   = '0;
            mask_d  = '0;
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            acc_d = acc_final;
            unique case (state_q)
                IDLE: begin
                    state_d = SCAN;
                end
                SCAN: begin
                    if (frame_end_i) begin
                        acc_d = '0;
                        if (acc_final != '0) begin
                            mask_d  = acc_final;
                            valid_d = 1'b1;
                            state_d = REPORT;
                        end
                    end
                end
                REPORT: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        state_d = SCAN;
                    end
                    if (frame_end_i) begin
                        acc_d = '0;
                        if (acc_final != '0) begin
                            if (handshake) begin
                                // Back-to-back: the slot frees this cycle, reload it.
                                mask_d  = acc_final;
                                valid_d = 1'b1;
                                state_d = REPORT;
                            end else begin
                                drop_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (score_clr_i) begin
            score_d = '0;
        end else if (handshake) begin
            if (sum > MAX_W) begin
                score_d = SCORE_WIDTH'(MAX_W);
            end else begin
                score_d = SCORE_WIDTH'(sum);
            end
        end
    end

    // All state registers with synchronous active-high reset.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            score_q <= score_d;
        end
    end

endmodule

// File: tb/tb_bullet_hit_judge.sv
// Directed testbench for bullet_hit_judge with hand-computed expectations.
`ifndef GAME_STATUS_BIT_LEN
`define GAME_STATUS_BIT_LEN 2
`endif
`ifndef GAME_STATUS_RUN
`define GAME_STATUS_RUN 2'd1
`endif

module tb_bullet_hit_judge;

    localparam int N = 4;

    logic                            clk_vga;
    logic                            rst;
    logic [`GAME_STATUS_BIT_LEN-1:0] game_status;
    logic                            frame_start;
    logic                            frame_end;
    logic                            bullet_alpha;
    logic [N-1:0]                    enemy_alpha;
    logic                            score_clr;
    logic                            crash;
    logic [13:0]                     score;
    logic                            drop;

    int n_tests;
    int n_fail;

    bullet_hit_judge_if #(.ENEMY_NUM(N)) hif ();

    bullet_hit_judge #(
        .ENEMY_NUM    (N),
        .SCORE_WIDTH  (14),
        .SCORE_PER_HIT(1),
        .SCORE_MAX    (9999)
    ) dut (
        .clk_vga             (clk_vga),
        .rst                 (rst),
        .game_status_i       (game_status),
        .frame_start_i       (frame_start),
        .frame_end_i         (frame_end),
        .bullet_alpha_i      (bullet_alpha),
        .enemy_alpha_i       (enemy_alpha),
        .score_clr_i         (score_clr),
        .crash_enemy_bullet_o(crash),
        .hit_if              (hif.master),
        .score_o             (score),
        .report_drop_o       (drop)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one pixel, check the combinational crash flag, then advance one clock.
    task automatic px(input logic b, input logic [N-1:0] e, input logic fs, input logic fe,
                      input logic exp_crash);
        bullet_alpha = b;
        enemy_alpha  = e;
        frame_start  = fs;
        frame_end    = fe;
        #1;
        check_eq("crash", {31'd0, crash}, {31'd0, exp_crash});
        @(posedge clk_vga);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        game_status   = '0;
        frame_start   = 1'b0;
        frame_end     = 1'b0;
        bullet_alpha  = 1'b0;
        enemy_alpha   = '0;
        score_clr     = 1'b0;
        hif.hit_ready = 1'b0;

        repeat (3) @(posedge clk_vga);
        #1;
        check_eq("rst_valid", {31'd0, hif.hit_valid}, 0);
        check_eq("rst_mask", {28'd0, hif.hit_mask}, 0);
        check_eq("rst_score", {18'd0, score}, 0);
        check_eq("rst_drop", {31'd0, drop}, 0);

        rst         = 1'b0;
        game_status = `GAME_STATUS_RUN;
        px(0, 4'b0000, 0, 0, 0);

        // Three overlapping pixels on enemy 2, accepted immediately.
        hif.hit_ready = 1'b1;
        px(0, 4'b0000, 1, 0, 0);
        px(1, 4'b0000, 0, 0, 0);
        px(1, 4'b0100, 0, 0, 1);
        px(1, 4'b0100, 0, 0, 1);
        px(1, 4'b0100, 0, 0, 1);
        px(0, 4'b0100, 0, 0, 0);
        px(0, 4'b0000, 0, 1, 0);
        check_eq("t1_valid", {31'd0, hif.hit_valid}, 1);
        check_eq("t1_mask", {28'd0, hif.hit_mask}, 32'b0100);
        check_eq("t1_score_pre", {18'd0, score}, 0);
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t1_valid_off", {31'd0, hif.hit_valid}, 0);
        check_eq("t1_score", {18'd0, score}, 1);

        // Enemies 0 and 3, consumer stalls for 10 cycles.
        hif.hit_ready = 1'b0;
        px(0, 4'b0000, 1, 0, 0);
        px(1, 4'b0001, 0, 0, 1);
        px(1, 4'b1000, 0, 0, 1);
        px(0, 4'b0000, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            check_eq("t2_hold_valid", {31'd0, hif.hit_valid}, 1);
            check_eq("t2_hold_mask", {28'd0, hif.hit_mask}, 32'b1001);
            check_eq("t2_hold_score", {18'd0, score}, 1);
            px(0, 4'b0000, 0, 0, 0);
        end
        hif.hit_ready = 1'b1;
        check_eq("t2_acc_valid", {31'd0, hif.hit_valid}, 1);
        check_eq("t2_acc_mask", {28'd0, hif.hit_mask}, 32'b1001);
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t2_valid_off", {31'd0, hif.hit_valid}, 0);
        check_eq("t2_score", {18'd0, score}, 3);
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t2_score_once", {18'd0, score}, 3);

        // Pending 1001 report overrun by a frame hitting enemy 1.
        hif.hit_ready = 1'b0;
        px(0, 4'b0000, 1, 0, 0);
        px(1, 4'b1001, 0, 0, 1);
        px(0, 4'b0000, 0, 1, 0);
        check_eq("t3_valid", {31'd0, hif.hit_valid}, 1);
        px(0, 4'b0000, 1, 0, 0);
        px(1, 4'b0010, 0, 0, 1);
        px(0, 4'b0000, 0, 1, 0);
        check_eq("t3_drop", {31'd0, drop}, 1);
        check_eq("t3_valid_held", {31'd0, hif.hit_valid}, 1);
        check_eq("t3_mask_held", {28'd0, hif.hit_mask}, 32'b1001);
        hif.hit_ready = 1'b1;
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t3_score", {18'd0, score}, 5);
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t3_no_late_report", {31'd0, hif.hit_valid}, 0);

        // Clear, then pump 1-pixel frames back-to-back up to 9998.
        hif.hit_ready = 1'b0;
        score_clr     = 1'b1;
        px(0, 4'b0000, 0, 0, 0);
        score_clr = 1'b0;
        check_eq("t4_clr", {18'd0, score}, 0);
        hif.hit_ready = 1'b1;
        px(1, 4'b0011, 1, 1, 1);
        for (int i = 0; i < 2499; i++) begin
            px(1, 4'b1111, 1, 1, 1);
        end
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t4_score_9998", {18'd0, score}, 9998);
        check_eq("t4_valid_off", {31'd0, hif.hit_valid}, 0);
        hif.hit_ready = 1'b0;
        px(1, 4'b1111, 1, 1, 1);
        check_eq("t4_mask_1111", {28'd0, hif.hit_mask}, 32'b1111);
        hif.hit_ready = 1'b1;
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t4_sat", {18'd0, score}, 9999);
        hif.hit_ready = 1'b0;
        px(1, 4'b1111, 1, 1, 1);
        hif.hit_ready = 1'b1;
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t4_sat_hold", {18'd0, score}, 9999);
        // Stray hit before a 1-pixel frame must not leak into that frame's mask.
        hif.hit_ready = 1'b0;
        px(1, 4'b1000, 0, 0, 1);
        px(1, 4'b0001, 1, 1, 1);
        check_eq("t4_degen_mask", {28'd0, hif.hit_mask}, 32'b0001);
        check_eq("t4_degen_valid", {31'd0, hif.hit_valid}, 1);
        hif.hit_ready = 1'b1;
        score_clr     = 1'b1;
        px(0, 4'b0000, 0, 0, 0);
        score_clr = 1'b0;
        check_eq("t4_clr_prio", {18'd0, score}, 0);
        check_eq("t4_clr_valid", {31'd0, hif.hit_valid}, 0);

        // Leave RUN with a report pending.
        hif.hit_ready = 1'b0;
        px(1, 4'b0010, 1, 1, 1);
        check_eq("t5_valid", {31'd0, hif.hit_valid}, 1);
        game_status = '0;
        px(1, 4'b1111, 0, 0, 0);
        check_eq("t5_valid_off", {31'd0, hif.hit_valid}, 0);
        check_eq("t5_mask_off", {28'd0, hif.hit_mask}, 0);
        check_eq("t5_drop_kept", {31'd0, drop}, 1);
        check_eq("t5_score_kept", {18'd0, score}, 0);
        game_status = `GAME_STATUS_RUN;
        px(0, 4'b0000, 0, 0, 0);

        // Bullet and enemies present but never on the same pixel.
        px(0, 4'b0000, 1, 0, 0);
        px(1, 4'b0000, 0, 0, 0);
        px(0, 4'b1111, 0, 0, 0);
        px(0, 4'b0000, 0, 1, 0);
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t6_no_valid", {31'd0, hif.hit_valid}, 0);
        check_eq("t6_score", {18'd0, score}, 0);

        // Reset in the middle of a pending report.
        hif.hit_ready = 1'b1;
        px(1, 4'b0001, 1, 1, 1);
        px(0, 4'b0000, 0, 0, 0);
        check_eq("t7_score_pre", {18'd0, score}, 1);
        hif.hit_ready = 1'b0;
        px(1, 4'b0100, 1, 1, 1);
        check_eq("t7_valid_pre", {31'd0, hif.hit_valid}, 1);
        rst = 1'b1;
        px(0, 4'b0000, 0, 0, 0);
        rst = 1'b0;
        check_eq("t7_valid", {31'd0, hif.hit_valid}, 0);
        check_eq("t7_mask", {28'd0, hif.hit_mask}, 0);
        check_eq("t7_score", {18'd0, score}, 0);
        check_eq("t7_drop", {31'd0, drop}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
